// File: rtl/jtag_tck_master.sv
// jtag_tck_master: command-driven JTAG shift engine.
// Takes one shift command of up to 32 bits. It drives TCK/TMS/TDI, captures TDO
// and returns the captured word with a one-cycle response pulse.
// The TCK half-period is CLK_DIV clk_i cycles.
// Optional build macro JTAG_TCK_MASTER_TMS_EXIT_EN: when it is defined, cmd_exit_i
// raises TMS on the final bit of the command. This lets one command leave a
// Shift-DR/IR state.
module jtag_tck_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_len_i,
  input  logic        cmd_tms_i,
  input  logic        cmd_exit_i,
  input  logic [31:0] cmd_tdi_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_tdo_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_phaseCnt;
  logic [4:0]  r_bitIdx;
  logic [5:0]  r_len;
  logic        r_tms;
  logic [31:0] r_tdi;
  logic [31:0] r_tdoCap;
  logic [31:0] r_rspTdo;
  logic        r_tck;
  logic        r_tmsOut;
  logic        r_tdiOut;
  logic        r_rspValid;

  logic [5:0]  w_lenEff;
  logic        w_accept;
  logic        w_zeroLen;
  logic        w_phaseEnd;
  logic        w_lowEnd;
  logic        w_highEnd;
  logic        w_lastBit;
  logic        w_finish;
  logic        w_advance;
  logic [4:0]  w_nextIdx;
  logic [31:0] w_tdoNext;
  logic        w_startTms;
  logic        w_nextTms;

`ifdef JTAG_TCK_MASTER_TMS_EXIT_EN
  logic        r_exit;
`else
  logic        w_unusedExit;
  assign w_unusedExit = cmd_exit_i;
`endif

  // Decode the handshake, phase boundaries and bit position for the state machine.
  always_comb begin
    w_lenEff   = (cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;
    w_accept   = (r_state == ST_IDLE) && cmd_valid_i;
    w_zeroLen  = (w_lenEff == 6'd0);
    w_phaseEnd = (r_phaseCnt == PHASE_LAST);
    w_lowEnd   = (r_state == ST_LOW) && w_phaseEnd;
    w_highEnd  = (r_state == ST_HIGH) && w_phaseEnd;
    w_lastBit  = ({1'b0, r_bitIdx} == (r_len - 6'd1));
    w_finish   = w_highEnd && w_lastBit;
    w_advance  = w_highEnd && !w_lastBit;
    w_nextIdx  = r_bitIdx + 5'd1;
  end

  // Merge the TDO sample for the current bit into the partially captured word.
  always_comb begin
    w_tdoNext = r_tdoCap;
    w_tdoNext[r_bitIdx] = tdo_i;
  end

  // Select the TMS level for the first bit and for the bit that comes next.
  always_comb begin
`ifdef JTAG_TCK_MASTER_TMS_EXIT_EN
    w_startTms = cmd_tms_i | (cmd_exit_i & (w_lenEff == 6'd1));
    w_nextTms  = r_tms | (r_exit & ({1'b0, w_nextIdx} == (r_len - 6'd1)));
`else
    w_startTms = cmd_tms_i;
    w_nextTms  = r_tms;
`endif
  end

  // Main sequencer: IDLE -> (LOW -> HIGH) per bit -> DONE -> IDLE.
  // A zero-length command skips straight to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_phaseCnt <= 8'd0;
      r_bitIdx   <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_phaseCnt <= 8'd0;
            r_bitIdx   <= 5'd0;
            r_state    <= w_zeroLen ? ST_DONE : ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_phaseEnd) begin
            r_phaseCnt <= 8'd0;
            r_state    <= ST_HIGH;
          end else begin
            r_phaseCnt <= r_phaseCnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (w_phaseEnd) begin
            r_phaseCnt <= 8'd0;
            if (w_lastBit) begin
              r_state <= ST_DONE;
            end else begin
              r_state  <= ST_LOW;
              r_bitIdx <= w_nextIdx;
            end
          end else begin
            r_phaseCnt <= r_phaseCnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Latch the command at the handshake so that later input changes cannot affect it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len <= 6'd0;
      r_tms <= 1'b0;
      r_tdi <= 32'd0;
    end else if (w_accept) begin
      r_len <= w_lenEff;
      r_tms <= cmd_tms_i;
      r_tdi <= cmd_tdi_i;
    end
  end

`ifdef JTAG_TCK_MASTER_TMS_EXIT_EN
  // Hold the exit request so it can be applied to the final bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exit <= 1'b0;
    end else if (w_accept) begin
      r_exit <= cmd_exit_i;
    end
  end
`endif

  // Drive the JTAG pins. TMS and TDI change only together with a falling TCK
  // (or when a command starts), so they are stable around the rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tck    <= 1'b0;
      r_tmsOut <= 1'b1;
      r_tdiOut <= 1'b0;
    end else begin
      if (w_lowEnd) begin
        r_tck <= 1'b1;
      end else if (w_highEnd) begin
        r_tck <= 1'b0;
      end
      if (w_accept && !w_zeroLen) begin
        r_tmsOut <= w_startTms;
        r_tdiOut <= cmd_tdi_i[0];
      end else if (w_advance) begin
        r_tmsOut <= w_nextTms;
        r_tdiOut <= r_tdi[w_nextIdx];
      end
    end
  end

  // Capture TDO at the end of each high phase and publish the word on completion.
  // The word is cleared at the handshake, so bits past the length read as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tdoCap   <= 32'd0;
      r_rspTdo   <= 32'd0;
      r_rspValid <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      if (w_accept) begin
        r_tdoCap <= 32'd0;
        if (w_zeroLen) begin
          r_rspTdo   <= 32'd0;
          r_rspValid <= 1'b1;
        end
      end else if (w_highEnd) begin
        r_tdoCap <= w_tdoNext;
        if (w_finish) begin
          r_rspTdo   <= w_tdoNext;
          r_rspValid <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign rsp_valid_o = r_rspValid;
  assign rsp_tdo_o   = r_rspTdo;
  assign tck_o       = r_tck;
  assign tms_o       = r_tmsOut;
  assign tdi_o       = r_tdiOut;

endmodule

// File: tb/tb_jtag_tck_master.sv
// Testbench for jtag_tck_master. It uses directed commands with literal expectations.
// A cycle-level reference model predicts every output, and a checker compares
// the design against that model on every falling clock edge.
`timescale 1ns/1ps
module tb_jtag_tck_master;

  localparam int D = 2;
`ifdef JTAG_TCK_MASTER_TMS_EXIT_EN
  localparam bit USE_EXIT = 1'b1;
`else
  localparam bit USE_EXIT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [5:0]  cmd_len_i = 6'd0;
  logic        cmd_tms_i = 1'b0;
  logic        cmd_exit_i = 1'b0;
  logic [31:0] cmd_tdi_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rsp_tdo_o;
  logic        tck_o;
  logic        tms_o;
  logic        tdi_o;
  logic        tdo_i;

  int nChecks = 0;
  int nFails  = 0;

  logic        tdoLoop = 1'b0;
  logic [31:0] tdoPat  = 32'd0;

  // Reference model state. mK counts cycles since the handshake.
  logic        mArmed = 1'b0;
  logic        mBusy = 1'b0;
  int          mK = 0;
  int          mN = 0;
  logic [31:0] mTdi = 32'd0;
  logic        mTms = 1'b0;
  logic        mExit = 1'b0;
  logic        mLoop = 1'b0;
  logic [31:0] mPat = 32'd0;
  logic        mLastTms = 1'b1;
  logic        mLastTdi = 1'b0;
  logic [31:0] mRspTdo = 32'd0;
  int          mBit;

  always #5 clk_i = ~clk_i;

  jtag_tck_master #(.CLK_DIV(D)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i),
    .cmd_tms_i(cmd_tms_i),
    .cmd_exit_i(cmd_exit_i),
    .cmd_tdi_i(cmd_tdi_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_tdo_o(rsp_tdo_o),
    .tck_o(tck_o),
    .tms_o(tms_o),
    .tdi_o(tdi_o),
    .tdo_i(tdo_i)
  );

  // The TDO source either loops back TDI or plays the pattern bit of the current shift position.
  always_comb begin
    mBit = 0;
    if (mBusy && mK >= 1) mBit = (mK - 1) / (2 * D);
    if (mBit > 31) mBit = 31;
  end
  assign tdo_i = mLoop ? tdi_o : mPat[mBit];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tmsOfBit(input int b, input int n, input logic tms, input logic ex);
    return tms | (USE_EXIT & ex & (b == n - 1));
  endfunction

  function automatic logic [31:0] expTdo(input int n, input logic loop,
                                         input logic [31:0] tdi, input logic [31:0] pat);
    logic [31:0] src;
    logic [31:0] r;
    src = loop ? tdi : pat;
    r = 32'd0;
    for (int b = 0; b < n; b++) r[b] = src[b];
    return r;
  endfunction

  // Reference model: accept a command when idle, then run for 2*D*N+1 cycles.
  always @(posedge clk_i) begin
    if (rst_i) begin
      mArmed   <= 1'b1;
      mBusy    <= 1'b0;
      mK       <= 0;
      mLastTms <= 1'b1;
      mLastTdi <= 1'b0;
      mRspTdo  <= 32'd0;
    end else if (mArmed && mBusy) begin
      if (mK == 2 * D * mN + 1) begin
        mBusy   <= 1'b0;
        mRspTdo <= expTdo(mN, mLoop, mTdi, mPat);
        if (mN > 0) begin
          mLastTms <= tmsOfBit(mN - 1, mN, mTms, mExit);
          mLastTdi <= mTdi[mN - 1];
        end
      end else begin
        mK <= mK + 1;
      end
    end else if (mArmed && cmd_valid_i) begin
      mBusy <= 1'b1;
      mK    <= 1;
      mN    <= (cmd_len_i > 6'd32) ? 32 : int'(cmd_len_i);
      mTdi  <= cmd_tdi_i;
      mTms  <= cmd_tms_i;
      mExit <= cmd_exit_i;
      mLoop <= tdoLoop;
      mPat  <= tdoPat;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_i) begin : compare
    int b;
    logic eTck, eTms, eTdi, eValid;
    logic [31:0] eRsp;
    if (mArmed) begin
      eTck = 1'b0;
      eTms = mLastTms;
      eTdi = mLastTdi;
      if (mBusy && mN > 0) begin
        b = (mK - 1) / (2 * D);
        if (b > mN - 1) b = mN - 1;
        eTms = tmsOfBit(b, mN, mTms, mExit);
        eTdi = mTdi[b];
        eTck = (mK <= 2 * D * mN) && (((mK - 1) % (2 * D)) >= D);
      end
      eValid = mBusy && (mK == 2 * D * mN + 1);
      eRsp = eValid ? expTdo(mN, mLoop, mTdi, mPat) : mRspTdo;
      checkVal("cmd_ready_o", {31'd0, cmd_ready_o}, {31'd0, !mBusy && !rst_i});
      checkVal("tck_o", {31'd0, tck_o}, {31'd0, eTck});
      checkVal("tms_o", {31'd0, tms_o}, {31'd0, eTms});
      checkVal("tdi_o", {31'd0, tdi_o}, {31'd0, eTdi});
      checkVal("rsp_valid_o", {31'd0, rsp_valid_o}, {31'd0, eValid});
      checkVal("rsp_tdo_o", rsp_tdo_o, eRsp);
    end
  end

  // Issue one command and record what the pins did until the response pulse.
  // It must be entered in an idle cycle, shortly after a rising edge.
  task automatic applyStimulus(input logic [5:0] len, input logic tms, input logic ex,
                               input logic [31:0] tdi, input logic loop, input logic [31:0] pat,
                               output int pulses, output int highCycles, output int firstHigh,
                               output int validCycle, output logic [31:0] tdoSeen,
                               output logic [31:0] tmsBits);
    logic prevTck;
    pulses = 0; highCycles = 0; firstHigh = -1; validCycle = -1;
    tdoSeen = 32'd0; tmsBits = 32'd0; prevTck = 1'b0;
    tdoLoop = loop; tdoPat = pat;
    cmd_len_i = len; cmd_tms_i = tms; cmd_exit_i = ex; cmd_tdi_i = tdi; cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    cmd_len_i = 6'd63; cmd_tms_i = ~tms; cmd_exit_i = ~ex; cmd_tdi_i = ~tdi;
    for (int cyc = 1; cyc <= 300 && validCycle < 0; cyc++) begin
      @(negedge clk_i);
      if (tck_o) begin
        highCycles++;
        if (firstHigh < 0) firstHigh = cyc;
        if (!prevTck) pulses++;
      end
      if (((cyc - 1) % (2 * D)) == 0 && ((cyc - 1) / (2 * D)) < 32) tmsBits[(cyc - 1) / (2 * D)] = tms_o;
      if (rsp_valid_o) begin
        validCycle = cyc;
        tdoSeen = rsp_tdo_o;
      end
      prevTck = tck_o;
      @(posedge clk_i); #1;
    end
    if (validCycle < 0) checkVal("rspTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (mBusy && n < 400) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (mBusy) checkVal("idleTimeout", 32'd1, 32'd0);
  endtask

  initial begin
    int pulses, highCycles, firstHigh, validCycle, acceptCyc, firstRspCyc, validSeen;
    logic [31:0] tdoSeen, tmsBits, firstRsp;

    // Hold reset for a few cycles, then confirm the documented reset values.
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checkVal("readyInReset", {31'd0, cmd_ready_o}, 32'd0);
    checkVal("resetTck", {31'd0, tck_o}, 32'd0);
    checkVal("resetTms", {31'd0, tms_o}, 32'd1);
    checkVal("resetTdi", {31'd0, tdi_o}, 32'd0);
    checkVal("resetRspValid", {31'd0, rsp_valid_o}, 32'd0);
    checkVal("resetRspTdo", rsp_tdo_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkVal("readyAfterRelease", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk_i); #1;

    // Single bit: TCK is high in cycles 3-4 and the response comes in cycle 5.
    applyStimulus(6'd1, 1'b0, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFF,
                  pulses, highCycles, firstHigh, validCycle, tdoSeen, tmsBits);
    checkVal("len1FirstHigh", firstHigh, 32'd3);
    checkVal("len1HighCycles", highCycles, 32'd2);
    checkVal("len1Pulses", pulses, 32'd1);
    checkVal("len1ValidCycle", validCycle, 32'd5);
    checkVal("len1Tdo", tdoSeen, 32'h0000_0001);

    // Full 32-bit loopback.
    applyStimulus(6'd32, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b1, 32'd0,
                  pulses, highCycles, firstHigh, validCycle, tdoSeen, tmsBits);
    checkVal("len32Pulses", pulses, 32'd32);
    checkVal("len32ValidCycle", validCycle, 32'd129);
    checkVal("len32Tdo", tdoSeen, 32'hA5A5_5A5A);

    // A zero-length command produces no TCK activity and a zero response.
    applyStimulus(6'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF,
                  pulses, highCycles, firstHigh, validCycle, tdoSeen, tmsBits);
    checkVal("len0HighCycles", highCycles, 32'd0);
    checkVal("len0ValidCycle", validCycle, 32'd1);
    checkVal("len0Tdo", tdoSeen, 32'd0);

    // An oversized length is clamped to 32 bits.
    applyStimulus(6'd40, 1'b0, 1'b0, 32'h0F0F_0F0F, 1'b0, 32'h1234_5678,
                  pulses, highCycles, firstHigh, validCycle, tdoSeen, tmsBits);
    checkVal("len40Pulses", pulses, 32'd32);
    checkVal("len40ValidCycle", validCycle, 32'd129);
    checkVal("len40Tdo", tdoSeen, 32'h1234_5678);

    // A short command masks off the upper capture bits.
    applyStimulus(6'd7, 1'b1, 1'b0, 32'h0000_0055, 1'b0, 32'hFFFF_FFFF,
                  pulses, highCycles, firstHigh, validCycle, tdoSeen, tmsBits);
    checkVal("len7Pulses", pulses, 32'd7);
    checkVal("len7ValidCycle", validCycle, 32'd29);
    checkVal("len7Tdo", tdoSeen, 32'h0000_007F);

    // The exit request affects only the final bit, and only when the feature is built in.
    applyStimulus(6'd5, 1'b0, 1'b1, 32'h0000_0013, 1'b1, 32'd0,
                  pulses, highCycles, firstHigh, validCycle, tdoSeen, tmsBits);
    checkVal("exitTmsBits", {27'd0, tmsBits[4:0]}, USE_EXIT ? 32'h0000_0010 : 32'h0000_0000);
    checkVal("exitTdo", tdoSeen, 32'h0000_0013);

    // Reset during the high phase of bit 3 of an 8-bit command.
    tdoLoop = 1'b0; tdoPat = 32'd0;
    cmd_len_i = 6'd8; cmd_tms_i = 1'b0; cmd_exit_i = 1'b0; cmd_tdi_i = 32'h0000_00FF;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checkVal("abortTckBefore", {31'd0, tck_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkVal("abortTck", {31'd0, tck_o}, 32'd0);
    checkVal("abortTms", {31'd0, tms_o}, 32'd1);
    checkVal("abortTdi", {31'd0, tdi_o}, 32'd0);
    checkVal("abortReady", {31'd0, cmd_ready_o}, 32'd1);
    validSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) validSeen++;
    end
    checkVal("abortNoRsp", validSeen, 32'd0);
    @(posedge clk_i); #1;

    // Keep valid high with changing TDI while busy. Only the first command runs,
    // and the next one is taken in cycle 2*D*N+2.
    tdoLoop = 1'b1;
    cmd_len_i = 6'd4; cmd_tms_i = 1'b0; cmd_exit_i = 1'b0; cmd_tdi_i = 32'h0000_000A;
    cmd_valid_i = 1'b1;
    acceptCyc = -1; firstRspCyc = -1; firstRsp = 32'd0;
    for (int cyc = 0; cyc <= 40 && acceptCyc < 0; cyc++) begin
      @(negedge clk_i);
      if (cyc > 0 && cmd_ready_o) acceptCyc = cyc;
      if (rsp_valid_o && firstRspCyc < 0) begin
        firstRspCyc = cyc;
        firstRsp = rsp_tdo_o;
      end
      @(posedge clk_i); #1;
      if (acceptCyc < 0) cmd_tdi_i = $urandom;
    end
    cmd_valid_i = 1'b0;
    checkVal("busyFirstRspCycle", firstRspCyc, 32'd17);
    checkVal("busyFirstRspTdo", firstRsp, 32'h0000_000A);
    checkVal("busySecondAccept", acceptCyc, 32'd18);
    waitIdle();
    repeat (3) @(posedge clk_i);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/jtag_tck_master.md
JTAG_TCK_MASTER -- requirements
Module: jtag_tck_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning TCK half-period in clk_i cycles (legal range 1..255).
REQ-002 SHALL have port clk_i  input  1  the single block clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid_i  input  1  shift command offered.
REQ-005 SHALL have port cmd_ready_o  output  1  block idle, command accepted when valid&ready.
REQ-006 SHALL have port cmd_len_i  input  6  bit count (0..63).
REQ-007 SHALL have port cmd_tms_i  input  1  TMS level for the command.
REQ-008 SHALL have port cmd_exit_i  input  1  raise TMS on final bit (see Configuration).
REQ-009 SHALL have port cmd_tdi_i  input  32  TDI bits, LSB shifted first.
REQ-010 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_tdo_o  output  32  captured TDO, bit i = i-th shifted bit.
REQ-012 SHALL have ports tck_o output 1, tms_o output 1, tdi_o output 1 (JTAG drive) and tdo_i input 1 (JTAG return, pre-synchronized externally).

Function
REQ-013 SHALL implement states IDLE, LOW, HIGH, DONE; cmd_ready_o = 1 only in IDLE.
REQ-014 SHALL, on handshake, register len, tms, exit and tdi; later input changes SHALL have no effect on the command.
REQ-015 SHALL clamp len 33..63 to 32; len 0 SHALL go IDLE->DONE with no TCK edges and rsp_tdo_o = 0.
REQ-016 SHALL, in the cycle after handshake, enter LOW with tck_o = 0, tms_o and tdi_o presenting bit 0.
REQ-017 SHALL hold LOW for CLK_DIV cycles, then HIGH (tck_o = 1) for CLK_DIV cycles.
REQ-018 SHALL sample tdo_i into bit i at the clk_i edge ending the HIGH phase of bit i.
REQ-019 SHALL, at end of HIGH for bit i < N-1, return to LOW with tdi_o/tms_o updated to bit i+1 in the same cycle tck_o falls.
REQ-020 SHALL, at end of HIGH for bit N-1, enter DONE: tck_o = 0, rsp_valid_o = 1 for exactly one cycle, then IDLE.
REQ-021 SHALL assert rsp_valid_o in cycle 2*CLK_DIV*N+1 counting the handshake cycle as 0; next handshake earliest in cycle 2*CLK_DIV*N+2.
REQ-022 SHALL zero rsp_tdo_o bits N..31; rsp_tdo_o SHALL hold its value until the next DONE.
REQ-023 SHALL hold tms_o and tdi_o at last driven values while IDLE; tck_o SHALL be 0 outside HIGH.
REQ-024 SHALL ignore cmd_valid_i while not in IDLE.

Reset
REQ-025 SHALL, with rst_i high at a clock edge, force IDLE, tck_o = 0, tms_o = 1, tdi_o = 0, rsp_valid_o = 0, rsp_tdo_o = 0.
REQ-026 SHALL hold cmd_ready_o = 0 while rst_i is high; 1 in the first cycle after release.
REQ-027 SHALL abort an in-flight command on reset with no rsp_valid_o pulse for it.

Configuration
REQ-028 SHALL support macro JTAG_TCK_MASTER_TMS_EXIT_EN.
REQ-029 SHALL, with the macro defined, drive tms_o = cmd_tms_i | cmd_exit_i during bit N-1 and cmd_tms_i for earlier bits.
REQ-030 SHALL, without the macro, drive tms_o = cmd_tms_i for all bits and ignore cmd_exit_i.

Verification
REQ-031 SHALL cover: CLK_DIV=2, len=1, tdi=1, tdo_i=1 -> tck_o high cycles 3-4, rsp_valid_o cycle 5, rsp_tdo_o = 0x00000001.
REQ-032 SHALL cover: len=32, tdi=0xA5A5_5A5A, tdo_i looped from tdi_o -> rsp_tdo_o = 0xA5A5_5A5A, 32 TCK pulses, rsp_valid_o cycle 129.
REQ-033 SHALL cover: len=0 -> no tck_o edge, rsp_valid_o cycle 1, rsp_tdo_o = 0; len=40 -> exactly 32 TCK pulses.
REQ-034 SHALL cover: macro defined, len=5, tms=0, exit=1 -> tms_o 0 for bits 0-3, 1 for bit 4; macro undefined -> tms_o 0 throughout.
REQ-035 SHALL cover: rst_i pulsed during bit 3 of len=8 -> next cycle tck_o=0, tms_o=1, no rsp_valid_o; cmd_ready_o=1 after release.
REQ-036 SHALL cover: cmd_valid_i held high with changing cmd_tdi_i while busy -> only the first command executes; second accepted in cycle 2*CLK_DIV*N+2.
